// File: rtl/regfile_uart_dump_pkg.sv
// -----------------------------------------------------------------------------
// regfile_uart_dump_pkg
// Shared UART definitions for the register-file serial dump and the future
// receiver: FSM state encodings, the idle line level and the bit-period
// derivation from clock frequency and baud rate.
// -----------------------------------------------------------------------------
package regfile_uart_dump_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_START = 3'd2,
    ST_DATA  = 3'd3,
    ST_STOP  = 3'd4
  } uart_state_t;

  localparam logic UART_IDLE      = 1'b1;
  localparam logic UART_START_BIT = 1'b0;

  // Clocks per serial bit; integer division truncates (50 MHz / 115200 -> 434).
  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

  // Counter width able to hold CLKS_PER_BIT-1, never narrower than one bit.
  function automatic int timer_width(input int cpb);
    return (cpb > 1) ? $clog2(cpb) : 1;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// -----------------------------------------------------------------------------
// uart_bit_timer
// Down-counter that measures one serial bit period.
//   clk   in  system clock
//   rst   in  asynchronous reset, active-high (count cleared)
//   load  in  reload the counter with RELOAD (bit period minus one)
//   en    in  count enable
//   tick  out high in the last cycle of a bit period (count 0 while enabled)
// On terminal count the counter reloads itself, so back-to-back bits need no
// extra load cycle.
// -----------------------------------------------------------------------------
module uart_bit_timer #(
  parameter int WIDTH  = 4,
  parameter int RELOAD = 9
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic tick
);

  localparam logic [WIDTH-1:0] RELOAD_V = WIDTH'(RELOAD);

  logic [WIDTH-1:0] cnt_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (load) begin
      cnt_reg <= RELOAD_V;
    end else if (en) begin
      if (cnt_reg == '0) begin
        cnt_reg <= RELOAD_V;
      end else begin
        cnt_reg <= cnt_reg - WIDTH'(1);
      end
    end
  end

  assign tick = en && (cnt_reg == '0);

endmodule

// File: rtl/regfile_uart_dump.sv
// -----------------------------------------------------------------------------
// regfile_uart_dump
// Walks register addresses 0..NUM_REGS-1 through a register-file read port
// and transmits each value as one 8N1 byte (LSB first) on txd.
//   clk    in   system clock
//   rst    in   asynchronous reset, active-high; aborts any frame in flight
//   start  in   dump request, level-sampled, only honoured while idle
//   ra     out  read address to the register file (registered)
//   rd     in   register-file read data for ra (combinational read)
//   txd    out  serial line, idles high
//   busy   out  high from the cycle after start is accepted to the last stop bit
//   done   out  one-cycle pulse after the final stop bit of the dump
// On the board, ra feeds RegisterFile ra2 through a mux while busy and txd
// drives UART_TXD.
// -----------------------------------------------------------------------------
module regfile_uart_dump
  import regfile_uart_dump_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 115200,
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 3,
  parameter int NUM_REGS = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] ra,
  input  logic [DATA_W-1:0] rd,
  output logic              txd,
  output logic              busy,
  output logic              done
);

  localparam int                CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
  localparam int                TIMER_W      = timer_width(CLKS_PER_BIT);
  localparam logic [ADDR_W-1:0] LAST_RA      = ADDR_W'(NUM_REGS - 1);
  localparam logic [2:0]        LAST_BIT     = 3'(DATA_W - 1);

  uart_state_t       state_reg, state_next;
  logic [ADDR_W-1:0] ra_reg, ra_next;
  logic [DATA_W-1:0] shift_reg, shift_next;
  logic [2:0]        bit_idx_reg, bit_idx_next;
  logic              busy_reg, busy_next;
  logic              done_reg, done_next;
  logic              txd_reg, txd_next;
  logic              timer_load, timer_en, bit_tick;

  uart_bit_timer #(
    .WIDTH  (TIMER_W),
    .RELOAD (CLKS_PER_BIT - 1)
  ) u_bit_timer (
    .clk  (clk),
    .rst  (rst),
    .load (timer_load),
    .en   (timer_en),
    .tick (bit_tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      ra_reg      <= '0;
      shift_reg   <= '0;
      bit_idx_reg <= '0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      txd_reg     <= UART_IDLE;
    end else begin
      state_reg   <= state_next;
      ra_reg      <= ra_next;
      shift_reg   <= shift_next;
      bit_idx_reg <= bit_idx_next;
      busy_reg    <= busy_next;
      done_reg    <= done_next;
      txd_reg     <= txd_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    ra_next      = ra_reg;
    shift_next   = shift_reg;
    bit_idx_next = bit_idx_reg;
    busy_next    = busy_reg;
    done_next    = 1'b0;
    timer_load   = 1'b0;
    timer_en     = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        ra_next = '0;
        if (start) begin
          state_next = ST_LOAD;
          busy_next  = 1'b1;
        end
      end
      ST_LOAD: begin
        // ra has been stable for a full cycle; snapshot the register so later
        // writes cannot change the byte on the wire.
        shift_next   = rd;
        bit_idx_next = '0;
        timer_load   = 1'b1;
        state_next   = ST_START;
      end
      ST_START: begin
        timer_en = 1'b1;
        if (bit_tick) begin
          state_next = ST_DATA;
        end
      end
      ST_DATA: begin
        timer_en = 1'b1;
        if (bit_tick) begin
          if (bit_idx_reg == LAST_BIT) begin
            state_next = ST_STOP;
          end else begin
            bit_idx_next = bit_idx_reg + 3'd1;
            shift_next   = shift_reg >> 1;
          end
        end
      end
      ST_STOP: begin
        timer_en = 1'b1;
        if (bit_tick) begin
          if (ra_reg == LAST_RA) begin
            state_next = ST_IDLE;
            done_next  = 1'b1;
            busy_next  = 1'b0;
            ra_next    = '0;
          end else begin
            ra_next    = ra_reg + ADDR_W'(1);
            state_next = ST_LOAD;
          end
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase

    // txd is registered from the next state so the line never glitches.
    case (state_next)
      ST_START: txd_next = UART_START_BIT;
      ST_DATA:  txd_next = shift_next[0];
      default:  txd_next = UART_IDLE;
    endcase
  end

  assign ra   = ra_reg;
  assign txd  = txd_reg;
  assign busy = busy_reg;
  assign done = done_reg;

endmodule

// File: tb/tb_regfile_uart_dump.sv
module tb_regfile_uart_dump;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start8, start4;
  logic [2:0] ra8, ra4;
  logic [7:0] rd8, rd4;
  logic       txd8, txd4, busy8, busy4, done8, done4;

  logic [7:0] rf8 [8];
  logic [7:0] rf4 [8];
  assign rd8 = rf8[ra8];
  assign rd4 = rf4[ra4];

  regfile_uart_dump #(
    .CLK_FREQ(1000), .BAUD(100), .DATA_W(8), .ADDR_W(3), .NUM_REGS(8)
  ) dut8 (
    .clk(clk), .rst(rst), .start(start8), .ra(ra8), .rd(rd8),
    .txd(txd8), .busy(busy8), .done(done8)
  );

  regfile_uart_dump #(
    .CLK_FREQ(1000), .BAUD(100), .DATA_W(8), .ADDR_W(3), .NUM_REGS(4)
  ) dut4 (
    .clk(clk), .rst(rst), .start(start4), .ra(ra4), .rd(rd4),
    .txd(txd4), .busy(busy4), .done(done4)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int frames8 = 0, frames4 = 0;
  int done8_cnt = 0, done4_cnt = 0;
  logic [7:0] exp8[$];
  logic [7:0] exp4[$];

  always @(negedge clk) begin
    if (done8) done8_cnt <= done8_cnt + 1;
    if (done4) done4_cnt <= done4_cnt + 1;
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
               name, act, act, exp, exp, cyc);
    end
  endtask

  function automatic logic line_of(input int which);
    return (which == 0) ? txd8 : txd4;
  endfunction

  // Receiver: decodes frames off the line and scores them against the queue.
  task automatic uart_rx(input int which);
    logic       prev, cur, stop_bit;
    logic [7:0] data, exp_v;
    int         low_len;
    bit         aborted;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      cur = line_of(which);
      if (rst) begin
        prev = 1'b1;
      end else if (prev && !cur) begin
        aborted  = 1'b0;
        low_len  = 1;
        data     = '0;
        stop_bit = 1'b0;
        for (int c = 1; c < 10 && !aborted; c++) begin
          @(negedge clk);
          if (rst) aborted = 1'b1;
          else if (!line_of(which)) low_len++;
        end
        for (int b = 0; b < 8 && !aborted; b++) begin
          for (int w = 0; w < ((b == 0) ? 6 : 10) && !aborted; w++) begin
            @(negedge clk);
            if (rst) aborted = 1'b1;
          end
          if (!aborted) data[b] = line_of(which);
        end
        for (int w = 0; w < 10 && !aborted; w++) begin
          @(negedge clk);
          if (rst) aborted = 1'b1;
        end
        if (!aborted) begin
          stop_bit = line_of(which);
          if (which == 0) frames8++; else frames4++;
          $display("frame dut%0d: byte=%02h start_len=%0d stop=%0b cycle=%0d",
                   which, data, low_len, stop_bit, cyc);
          check("start_len", low_len, 10);
          check("stop_bit", int'(stop_bit), 1);
          if (which == 0) begin
            check("exp8_pending", int'(exp8.size() > 0), 1);
            if (exp8.size() > 0) begin
              exp_v = exp8.pop_front();
              check("frame8_byte", int'(data), int'(exp_v));
            end
          end else begin
            check("exp4_pending", int'(exp4.size() > 0), 1);
            if (exp4.size() > 0) begin
              exp_v = exp4.pop_front();
              check("frame4_byte", int'(data), int'(exp_v));
            end
          end
        end
        prev = 1'b1;
      end else begin
        prev = cur;
      end
    end
  endtask

  task automatic pulse_start(input int which, output int acc);
    @(posedge clk); #1;
    if (which == 0) start8 = 1'b1; else start4 = 1'b1;
    @(posedge clk); #1;
    acc = cyc;
    if (which == 0) start8 = 1'b0; else start4 = 1'b0;
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_done(input int which, input int acc, input int max_cyc,
                           output int lat, output int ra_max);
    bit seen;
    seen   = 1'b0;
    lat    = -1;
    ra_max = 0;
    for (int n = 0; n < max_cyc && !seen; n++) begin
      @(posedge clk); #1;
      if (which == 0) begin
        if (int'(ra8) > ra_max) ra_max = int'(ra8);
        if (done8) begin seen = 1'b1; lat = cyc - acc; end
      end else begin
        if (int'(ra4) > ra_max) ra_max = int'(ra4);
        if (done4) begin seen = 1'b1; lat = cyc - acc; end
      end
    end
    check("done_seen", int'(seen), 1);
  endtask

  task automatic push_dump8();
    for (int i = 0; i < 8; i++) exp8.push_back(rf8[i]);
  endtask

  initial begin
    int acc, acc2, lat, ramax, f0, d0;
    rst    = 1'b1;
    start8 = 1'b0;
    start4 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      rf8[i] = 8'(17 * i);
      rf4[i] = 8'h00;
    end
    rf4[0] = 8'h5A; rf4[1] = 8'hA5; rf4[2] = 8'h3C; rf4[3] = 8'h0F;
    fork
      uart_rx(0);
      uart_rx(1);
    join_none

    repeat (3) @(posedge clk);
    #1;
    check("rst_txd", int'(txd8), 1);
    check("rst_busy", int'(busy8), 0);
    check("rst_done", int'(done8), 0);
    check("rst_ra", int'(ra8), 0);
    rst = 1'b0;

    // Mid-cycle reset during r1's start bit: outputs clear before the next edge.
    pulse_start(0, acc);
    push_dump8();
    wait_cyc(acc + 107);
    check("pre_rst_txd", int'(txd8), 0);
    check("pre_rst_ra", int'(ra8), 1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_txd", int'(txd8), 1);
    check("async_rst_busy", int'(busy8), 0);
    check("async_rst_done", int'(done8), 0);
    check("async_rst_ra", int'(ra8), 0);
    check("frames_before_abort", frames8, 1);
    exp8.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Plain dump: 00,11,..,77 and a single done 808 cycles after acceptance.
    f0 = frames8; d0 = done8_cnt;
    pulse_start(0, acc);
    push_dump8();
    wait_done(0, acc, 1200, lat, ramax);
    check("dump_latency", lat, 808);
    check("dump_ra_max", ramax, 7);
    repeat (5) @(posedge clk);
    #1;
    check("dump_frames", frames8 - f0, 8);
    check("dump_done_pulses", done8_cnt - d0, 1);
    check("dump_idle_busy", int'(busy8), 0);
    check("dump_idle_ra", int'(ra8), 0);

    // Ignored re-start, late write to r2 after its snapshot, early write to r5.
    f0 = frames8; d0 = done8_cnt;
    pulse_start(0, acc);
    exp8.push_back(8'h00); exp8.push_back(8'h11); exp8.push_back(8'h22);
    exp8.push_back(8'h33); exp8.push_back(8'h44); exp8.push_back(8'hC3);
    exp8.push_back(8'h66); exp8.push_back(8'h77);
    wait_cyc(acc + 203);
    rf8[2] = 8'hFF;
    wait_cyc(acc + 230);
    start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    wait_cyc(acc + 250);
    rf8[5] = 8'hC3;
    wait_done(0, acc, 1200, lat, ramax);
    check("busy_restart_latency", lat, 808);
    repeat (20) @(posedge clk);
    #1;
    check("busy_restart_frames", frames8 - f0, 8);
    check("busy_restart_done_pulses", done8_cnt - d0, 1);
    check("busy_restart_not_queued", int'(busy8), 0);
    rf8[2] = 8'h22;
    rf8[5] = 8'h55;

    // start held high: a second dump begins the cycle after done.
    f0 = frames8; d0 = done8_cnt;
    push_dump8();
    push_dump8();
    @(posedge clk); #1;
    start8 = 1'b1;
    @(posedge clk); #1;
    acc = cyc;
    wait_done(0, acc, 1200, lat, ramax);
    check("held_first_latency", lat, 808);
    @(posedge clk); #1;
    check("held_retrigger_busy", int'(busy8), 1);
    check("held_retrigger_done_low", int'(done8), 0);
    acc2 = cyc;
    start8 = 1'b0;
    wait_done(0, acc2, 1200, lat, ramax);
    check("held_second_latency", lat, 808);
    repeat (5) @(posedge clk);
    #1;
    check("held_frames", frames8 - f0, 16);
    check("held_done_pulses", done8_cnt - d0, 2);

    // Reset during DATA bit 4 of r3's frame, then a clean restart from r0.
    f0 = frames8;
    pulse_start(0, acc);
    push_dump8();
    wait_cyc(acc + 357);
    check("abort_pre_ra", int'(ra8), 3);
    check("abort_pre_busy", int'(busy8), 1);
    #2 rst = 1'b1;
    #1;
    check("abort_ra", int'(ra8), 0);
    check("abort_busy", int'(busy8), 0);
    check("abort_txd", int'(txd8), 1);
    check("abort_frames", frames8 - f0, 3);
    exp8.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    f0 = frames8; d0 = done8_cnt;
    pulse_start(0, acc);
    push_dump8();
    wait_done(0, acc, 1200, lat, ramax);
    check("restart_latency", lat, 808);
    repeat (5) @(posedge clk);
    #1;
    check("restart_frames", frames8 - f0, 8);
    check("restart_done_pulses", done8_cnt - d0, 1);

    // Four-register build.
    f0 = frames4; d0 = done4_cnt;
    pulse_start(1, acc);
    for (int i = 0; i < 4; i++) exp4.push_back(rf4[i]);
    wait_done(1, acc, 700, lat, ramax);
    check("n4_latency", lat, 404);
    check("n4_ra_max", ramax, 3);
    repeat (5) @(posedge clk);
    #1;
    check("n4_frames", frames4 - f0, 4);
    check("n4_done_pulses", done4_cnt - d0, 1);
    check("n4_idle_ra", int'(ra4), 0);

    check("exp8_drained", exp8.size(), 0);
    check("exp4_drained", exp4.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
